operand_tile_loader: RTL

Double-buffered operand staging stage directly upstream of the sum-stationary systolic array. It accepts an N×N A tile and an N×N B tile, each row-major, one row per handshake. It then streams N beats into the array: A column k together with B row k on beat k, with `last` on beat N-1. While one bank drains into the array, the other bank fills, so back-to-back tiles stream without bubbles.

---
 rtl/operand_tile_pkg.sv | 22 ++
 rtl/operand_bank.sv | 120 ++++++++++++
 rtl/operand_tile_loader.sv | 114 +++++++++++
 3 files changed

// File: rtl/operand_tile_pkg.sv
// Shared types for the double-buffered operand tile loader.
// Bank states and small predicates used by both the bank and the top level.
package operand_tile_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int NUM_BANKS = 2;

    function automatic logic is_writable(input bank_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

    function automatic logic is_streamable(input bank_state_t s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/operand_bank.sv
// One staging bank: A/B tile storage, independent row counters and the
// EMPTY/FILLING/FULL/DRAINING state machine.
module operand_bank
    import operand_tile_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int KW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           a_row_wr,
    input  logic [N-1:0][DATA_WIDTH-1:0]   a_row_data,
    input  logic                           b_row_wr,
    input  logic [N-1:0][DATA_WIDTH-1:0]   b_row_data,
    input  logic [KW-1:0]                  k_sel,
    input  logic                           beat_xfer,
    input  logic                           drain_done,
    output bank_state_t                    state,
    output logic                           a_full,
    output logic                           b_full,
    output logic                           fill_done,
    output logic [N-1:0][DATA_WIDTH-1:0]   a_col,
    output logic [N-1:0][DATA_WIDTH-1:0]   b_row
);

    localparam int CW = $clog2(N + 1);

    bank_state_t                   r_state;
    bank_state_t                   w_state_next;
    logic [CW-1:0]                 r_a_cnt;
    logic [CW-1:0]                 r_b_cnt;
    logic [CW-1:0]                 w_a_cnt_next;
    logic [CW-1:0]                 w_b_cnt_next;
    logic [N-1:0][DATA_WIDTH-1:0]  r_a_mem [N];
    logic [N-1:0][DATA_WIDTH-1:0]  r_b_mem [N];

    assign w_a_cnt_next = r_a_cnt + CW'(a_row_wr);
    assign w_b_cnt_next = r_b_cnt + CW'(b_row_wr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY, FILLING: begin
                if (w_a_cnt_next == CW'(N) && w_b_cnt_next == CW'(N)) begin
                    w_state_next = FULL;
                end else if (a_row_wr || b_row_wr) begin
                    w_state_next = FILLING;
                end
            end
            FULL: begin
                // A one-beat tile finishes on its first transfer.
                if (drain_done) begin
                    w_state_next = EMPTY;
                end else if (beat_xfer) begin
                    w_state_next = DRAINING;
                end
            end
            DRAINING: begin
                if (drain_done) begin
                    w_state_next = EMPTY;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    always_comb begin
        state     = r_state;
        a_full    = (r_a_cnt == CW'(N));
        b_full    = (r_b_cnt == CW'(N));
        fill_done = is_writable(r_state) && (w_state_next == FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_cnt <= '0;
            r_b_cnt <= '0;
        end else if (drain_done) begin
            r_a_cnt <= '0;
            r_b_cnt <= '0;
        end else begin
            r_a_cnt <= w_a_cnt_next;
            r_b_cnt <= w_b_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_a_mem[gi] <= '0;
                    r_b_mem[gi] <= '0;
                end else begin
                    if (a_row_wr && r_a_cnt == CW'(gi)) begin
                        r_a_mem[gi] <= a_row_data;
                    end
                    if (b_row_wr && r_b_cnt == CW'(gi)) begin
                        r_b_mem[gi] <= b_row_data;
                    end
                end
            end

            // Column k of A is gathered across rows; B row k is read whole.
            assign a_col[gi] = r_a_mem[gi][k_sel];
        end
    endgenerate

    assign b_row = r_b_mem[k_sel];

endmodule

// File: rtl/operand_tile_loader.sv
// Double-buffered operand staging ahead of the systolic array: rows fill one
// bank while the other bank streams A columns / B rows, one beat per cycle.
module operand_tile_loader
    import operand_tile_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           a_row_valid,
    output logic                           a_row_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]   a_row_data,
    input  logic                           b_row_valid,
    output logic                           b_row_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]   b_row_data,
    output logic                           a_input_valid,
    output logic                           b_input_valid,
    input  logic                           input_ready,
    output logic [N-1:0][DATA_WIDTH-1:0]   a_data,
    output logic [N-1:0][DATA_WIDTH-1:0]   b_data,
    output logic                           last
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    logic                          r_started;
    logic                          r_wr_bank;
    logic                          r_rd_bank;
    logic [KW-1:0]                 r_k;

    bank_state_t                   w_state     [NUM_BANKS];
    logic                          w_a_full    [NUM_BANKS];
    logic                          w_b_full    [NUM_BANKS];
    logic                          w_fill_done [NUM_BANKS];
    logic [N-1:0][DATA_WIDTH-1:0]  w_a_col     [NUM_BANKS];
    logic [N-1:0][DATA_WIDTH-1:0]  w_b_row     [NUM_BANKS];

    logic                          w_wr_open;
    logic                          w_a_accept;
    logic                          w_b_accept;
    logic                          w_valid;
    logic                          w_last_beat;
    logic                          w_xfer;
    logic                          w_drain_done;

    assign w_wr_open    = is_writable(w_state[r_wr_bank]);
    assign a_row_ready  = r_started && w_wr_open && !w_a_full[r_wr_bank];
    assign b_row_ready  = r_started && w_wr_open && !w_b_full[r_wr_bank];
    assign w_a_accept   = a_row_valid && a_row_ready;
    assign w_b_accept   = b_row_valid && b_row_ready;

    // Valid depends only on registered bank state, never on input_ready.
    assign w_valid      = is_streamable(w_state[r_rd_bank]);
    assign w_last_beat  = (r_k == KW'(N - 1));
    assign w_xfer       = w_valid && input_ready;
    assign w_drain_done = w_xfer && w_last_beat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            operand_bank #(
                .DATA_WIDTH (DATA_WIDTH),
                .N          (N),
                .KW         (KW)
            ) u_bank (
                .clk        (clk),
                .reset      (reset),
                .a_row_wr   (w_a_accept && (r_wr_bank == 1'(gi))),
                .a_row_data (a_row_data),
                .b_row_wr   (w_b_accept && (r_wr_bank == 1'(gi))),
                .b_row_data (b_row_data),
                .k_sel      (r_k),
                .beat_xfer  (w_xfer && (r_rd_bank == 1'(gi))),
                .drain_done (w_drain_done && (r_rd_bank == 1'(gi))),
                .state      (w_state[gi]),
                .a_full     (w_a_full[gi]),
                .b_full     (w_b_full[gi]),
                .fill_done  (w_fill_done[gi]),
                .a_col      (w_a_col[gi]),
                .b_row      (w_b_row[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_started <= 1'b0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_k       <= '0;
        end else begin
            r_started <= 1'b1;
            if (w_fill_done[r_wr_bank]) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_xfer) begin
                r_k <= w_last_beat ? '0 : r_k + KW'(1);
            end
            if (w_drain_done) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    always_comb begin
        a_input_valid = w_valid;
        b_input_valid = w_valid;
        last          = w_valid && w_last_beat;
        a_data        = w_valid ? w_a_col[r_rd_bank] : '0;
        b_data        = w_valid ? w_b_row[r_rd_bank] : '0;
    end

endmodule
